// File: rtl/vision_decision_if.sv
// Frame-in / decision-out bundle for vision_decision.
// The source side (camera front-end or bench) uses the master modport; the
// decision block uses the slave modport.
interface vision_decision_if;
  // Per-frame 3x3 blob occupancy, bit n = quadrant n, row-major, 0 at top-left
  logic [8:0] quadrants_in;
  // Level-style frame strobe; quadrants_in is stable while it is high
  logic       quadrants_valid_in;
  // Committed lane: 0=left, 1=center, 2=right
  logic [1:0] lane;
  // High while a lane is committed
  logic       lane_valid;
  // One-cycle jump pulse
  logic       jump;
  // One-cycle pulse per processed frame
  logic       update;

  modport master (
    output quadrants_in,
    output quadrants_valid_in,
    input  lane,
    input  lane_valid,
    input  jump,
    input  update
  );

  modport slave (
    input  quadrants_in,
    input  quadrants_valid_in,
    output lane,
    output lane_valid,
    output jump,
    output update
  );
endinterface

// File: rtl/vision_decision.sv
// Lane tracker / jump detector fed by per-frame 3x3 quadrant occupancy.
// A frame is consumed on the rising edge of quadrants_valid_in; all results
// for that frame appear one cycle later, together with a one-cycle update.
// A lane candidate must persist STABLE_FRAMES frames before it is committed,
// LOST_FRAMES empty frames drop tracking, and a top-row-only blob edge fires
// a jump pulse subject to a JUMP_COOLDOWN frame hold-off.
module vision_decision #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned LOST_FRAMES   = 8,
  parameter int unsigned JUMP_COOLDOWN = 4
) (
  input logic              pixel_clock_in,
  input logic              reset_n_in,
  vision_decision_if.slave vd_bus
);

  localparam logic [3:0] StableCnt   = 4'(STABLE_FRAMES);
  localparam logic [3:0] LostCnt     = 4'(LOST_FRAMES);
  localparam logic [3:0] CooldownCnt = 4'(JUMP_COOLDOWN);

  typedef enum logic [0:0] {StIdle, StTrack} state_e;

  // State and registered outputs
  state_e     r_state;
  logic       r_valid_d;
  logic [1:0] r_lane;
  logic [3:0] r_pend_lane;
  logic [3:0] r_pend_cnt;
  logic [3:0] r_empty_cnt;
  logic       r_jump_prev;
  logic [3:0] r_cooldown;
  logic       r_jump;
  logic       r_update;

  // Frame decode
  logic [8:0] w_q;
  logic       w_event;
  logic [2:0] w_col;
  logic       w_empty;
  logic [1:0] w_left;
  logic [1:0] w_right;
  logic [2:0] w_sum;
  logic [1:0] w_cand;
  logic       w_jump_cond;

  // Next-state values, applied only on a frame event
  logic [3:0] w_pend_lane_nxt;
  logic [3:0] w_pend_cnt_upd;
  logic [3:0] w_pend_cnt_nxt;
  logic [3:0] w_empty_cnt_nxt;
  logic       w_commit;
  logic       w_lost;
  logic       w_jump_fire;
  logic [3:0] w_cooldown_nxt;

  assign w_q     = vd_bus.quadrants_in;
  // Only the first cycle of each valid assertion counts as a frame
  assign w_event = vd_bus.quadrants_valid_in & ~r_valid_d;

  // Column occupancy and lane candidate from outermost occupied columns
  always_comb begin
    w_col[0] = w_q[0] | w_q[3] | w_q[6];
    w_col[1] = w_q[1] | w_q[4] | w_q[7];
    w_col[2] = w_q[2] | w_q[5] | w_q[8];
    w_empty  = (w_col == 3'b000);

    if (w_col[0])      w_left = 2'd0;
    else if (w_col[1]) w_left = 2'd1;
    else               w_left = 2'd2;

    if (w_col[2])      w_right = 2'd2;
    else if (w_col[1]) w_right = 2'd1;
    else               w_right = 2'd0;

    w_sum  = {1'b0, w_left} + {1'b0, w_right};
    w_cand = w_sum[2:1];

    // Blob in the top row with nothing in the bottom row
    w_jump_cond = (w_q[2:0] != 3'b000) && (w_q[8:6] == 3'b000);
  end

  // Candidate filter, loss counter and jump/cooldown next-state
  always_comb begin
    w_pend_lane_nxt = r_pend_lane;
    w_pend_cnt_upd  = r_pend_cnt;
    w_pend_cnt_nxt  = r_pend_cnt;
    w_empty_cnt_nxt = r_empty_cnt;
    w_commit        = 1'b0;
    w_lost          = 1'b0;

    if (w_empty) begin
      w_empty_cnt_nxt = (r_empty_cnt == 4'hF) ? r_empty_cnt : r_empty_cnt + 4'd1;
      w_pend_cnt_nxt  = 4'd0;
      w_lost          = (r_state == StTrack) && (w_empty_cnt_nxt >= LostCnt);
    end else begin
      w_empty_cnt_nxt = 4'd0;
      if ((r_state == StTrack) && (w_cand == r_lane)) begin
        // Current lane confirmed again: abandon any pending switch
        w_pend_cnt_upd = 4'd0;
      end else if ({2'b00, w_cand} == r_pend_lane) begin
        w_pend_cnt_upd = (r_pend_cnt == 4'hF) ? r_pend_cnt : r_pend_cnt + 4'd1;
      end else begin
        w_pend_lane_nxt = {2'b00, w_cand};
        w_pend_cnt_upd  = 4'd1;
      end

      if (w_pend_cnt_upd == StableCnt) begin
        w_commit       = 1'b1;
        w_pend_cnt_nxt = 4'd0;
      end else begin
        w_pend_cnt_nxt = w_pend_cnt_upd;
      end
    end

    // A jump counts while tracking or on the frame that starts tracking
    w_jump_fire = w_jump_cond && !r_jump_prev && (r_cooldown == 4'd0) &&
                  ((r_state == StTrack) || w_commit);

    if (w_jump_fire)              w_cooldown_nxt = CooldownCnt;
    else if (r_cooldown != 4'd0)  w_cooldown_nxt = r_cooldown - 4'd1;
    else                          w_cooldown_nxt = 4'd0;
  end

  // Tracking FSM and all registered state; changes only on frame events
  always_ff @(posedge pixel_clock_in) begin
    if (!reset_n_in) begin
      r_state     <= StIdle;
      // Held high so a strobe already asserted at reset release is ignored
      r_valid_d   <= 1'b1;
      r_lane      <= 2'd1;
      r_pend_lane <= 4'd0;
      r_pend_cnt  <= 4'd0;
      r_empty_cnt <= 4'd0;
      r_jump_prev <= 1'b0;
      r_cooldown  <= 4'd0;
      r_jump      <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      r_valid_d <= vd_bus.quadrants_valid_in;
      r_update  <= w_event;
      r_jump    <= w_event & w_jump_fire;

      if (w_event) begin
        r_pend_lane <= w_pend_lane_nxt;
        r_pend_cnt  <= w_pend_cnt_nxt;
        r_empty_cnt <= w_empty_cnt_nxt;
        r_jump_prev <= w_jump_cond;
        r_cooldown  <= w_cooldown_nxt;

        if (w_commit) begin
          r_lane <= w_pend_lane_nxt[1:0];
        end

        unique case (r_state)
          StIdle: begin
            if (w_commit) r_state <= StTrack;
          end
          StTrack: begin
            // Lane keeps its last value when tracking is lost
            if (w_lost) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign vd_bus.lane       = r_lane;
  assign vd_bus.lane_valid = (r_state == StTrack);
  assign vd_bus.jump       = r_jump;
  assign vd_bus.update     = r_update;

endmodule

// File: tb/tb_vision_decision.sv
// Bench for vision_decision: a table of frames with hand-derived expected
// lane/lane_valid/jump, pushed to a scoreboard when each frame is driven and
// popped whenever the DUT pulses update. Reset corner cases are hand-written.
module tb_vision_decision;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vision_decision_if vif ();

  vision_decision #(
    .STABLE_FRAMES (3),
    .LOST_FRAMES   (8),
    .JUMP_COOLDOWN (4)
  ) dut (
    .pixel_clock_in (clk),
    .reset_n_in     (rst_n),
    .vd_bus         (vif)
  );

  typedef struct {
    logic [8:0]  q;
    int unsigned hold;
    logic [1:0]  lane;
    logic        lane_valid;
    logic        jump;
  } vec_t;

  typedef struct {
    logic [1:0] lane;
    logic       lane_valid;
    logic       jump;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[27];

  int total  = 0;
  int bad    = 0;
  int n_upd  = 0;
  int n_sent = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every update must match the oldest pending frame
  always @(negedge clk) begin
    if (vif.jump) check("jump_only_with_update", 32'(vif.update), 32'd1);
    if (vif.update) begin
      n_upd++;
      check("update_has_pending_frame", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_lane"},       32'(vif.lane),       32'(e.lane));
        check({e.name, "_lane_valid"}, 32'(vif.lane_valid), 32'(e.lane_valid));
        check({e.name, "_jump"},       32'(vif.jump),       32'(e.jump));
      end
    end
  end

  task automatic send(input logic [8:0] q, input int unsigned hold, input logic [1:0] l,
                      input logic v, input logic j, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    vif.quadrants_in       = q;
    vif.quadrants_valid_in = 1'b1;
    e.lane       = l;
    e.lane_valid = v;
    e.jump       = j;
    e.name       = name;
    sb.push_back(e);
    n_sent++;
    repeat (hold) @(posedge clk);
    #1;
    vif.quadrants_valid_in = 1'b0;
    // Garbage between frames must not be sampled
    vif.quadrants_in       = 9'($urandom);
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lane"},       32'(vif.lane),       32'd1);
    check({tag, "_lane_valid"}, 32'(vif.lane_valid), 32'd0);
    check({tag, "_jump"},       32'(vif.jump),       32'd0);
    check({tag, "_update"},     32'(vif.update),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int upd_before;

    // Expected values derived frame by frame for STABLE=3, LOST=8, COOLDOWN=4.
    // Commit to right lane after three col-2 frames.
    vecs[0]  = '{9'h004, 1, 2'd1, 1'b0, 1'b0};
    vecs[1]  = '{9'h004, 1, 2'd1, 1'b0, 1'b0};
    vecs[2]  = '{9'h004, 1, 2'd2, 1'b1, 1'b0};
    // col0, col0, col2 (resets pending), col0 x3 -> switch on last
    vecs[3]  = '{9'h040, 1, 2'd2, 1'b1, 1'b0};
    vecs[4]  = '{9'h040, 1, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{9'h100, 1, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{9'h040, 1, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{9'h040, 1, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{9'h040, 1, 2'd0, 1'b1, 1'b0};
    // Jump, then alternating top-row/empty frames held off by cooldown
    vecs[9]  = '{9'h002, 1, 2'd0, 1'b1, 1'b1};
    vecs[10] = '{9'h000, 1, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{9'h002, 1, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{9'h000, 1, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{9'h002, 1, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{9'h000, 1, 2'd0, 1'b1, 1'b0};
    vecs[15] = '{9'h002, 1, 2'd0, 1'b1, 1'b1};
    // Seven empties keep tracking, the eighth drops it, lane held
    for (int i = 16; i < 23; i++) vecs[i] = '{9'h000, 1, 2'd0, 1'b1, 1'b0};
    vecs[23] = '{9'h000, 1, 2'd0, 1'b0, 1'b0};
    // Valid held 5 cycles -> one frame only
    vecs[24] = '{9'h004, 5, 2'd0, 1'b0, 1'b0};
    // Bottom-only frame clears jump_prev, then commit frame fires a jump
    vecs[25] = '{9'h100, 1, 2'd0, 1'b0, 1'b0};
    vecs[26] = '{9'h004, 1, 2'd2, 1'b1, 1'b1};

    // Reset with valid already high; release must not create a frame
    rst_n                  = 1'b0;
    vif.quadrants_valid_in = 1'b1;
    vif.quadrants_in       = 9'h004;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("no_update_valid_held_at_release", 32'(n_upd), 32'd0);
    @(posedge clk);
    #1 vif.quadrants_valid_in = 1'b0;
    @(posedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].q, vecs[i].hold, vecs[i].lane, vecs[i].lane_valid, vecs[i].jump,
           $sformatf("vec%0d", i));
    end

    // Partial col-0 history, then reset mid-frame with valid high
    send(9'h040, 1, 2'd2, 1'b1, 1'b0, "pre_rst0");
    send(9'h040, 1, 2'd2, 1'b1, 1'b0, "pre_rst1");
    @(posedge clk);
    #1;
    vif.quadrants_in       = 9'h040;
    vif.quadrants_valid_in = 1'b1;
    rst_n                  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    upd_before = n_upd;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("no_pulse_after_reset_jump", 32'(vif.jump), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_update_after_mid_reset", 32'(n_upd), 32'(upd_before));
    @(posedge clk);
    #1 vif.quadrants_valid_in = 1'b0;
    @(posedge clk);

    // History discarded: three fresh frames needed to commit
    send(9'h040, 1, 2'd1, 1'b0, 1'b0, "post_rst0");
    send(9'h040, 1, 2'd1, 1'b0, 1'b0, "post_rst1");
    send(9'h040, 1, 2'd0, 1'b1, 1'b0, "post_rst2");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("update_count", 32'(n_upd), 32'(n_sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
